traffic_cmd_framer: RTL



---
 rtl/traffic_cmd_framer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/traffic_cmd_framer.sv
// Byte-stream to command framer: hunts for SYNC_BYTE, collects HDR/DMSB/DLSB (and CSUM when
// TRAFFIC_CMD_FRAMER_CSUM_EN is defined), validates, then strobes one command.
module traffic_cmd_framer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_CMD_TYPE   = 5,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  output logic [2:0]           cmd_type_o,
  output logic [15:0]          cmd_data_o,
  output logic                 cmd_valid_o,
  output logic                 frame_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned      IdleW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       MaxType  = 3'(MAX_CMD_TYPE);

  typedef enum logic [2:0] {
    StHunt,
    StHdr,
    StDmsb,
    StDlsb,
    StEmit
`ifdef TRAFFIC_CMD_FRAMER_CSUM_EN
    , StCsum
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [IdleW-1:0]     idle_q, idle_d;
  logic [2:0]           type_q, type_d;
  logic [7:0]           msb_q, msb_d;
  logic [7:0]           lsb_q, lsb_d;
  logic                 ready_q;
  logic                 cmd_valid_q;
  logic                 frame_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]           cmd_type_q, cmd_type_d;
  logic [15:0]          cmd_data_q, cmd_data_d;
  logic                 accept;
  logic                 in_frame;
  logic                 err;

  assign accept   = byte_valid_i & ready_q;
  assign in_frame = (state_q != StHunt) && (state_q != StEmit);

`ifdef TRAFFIC_CMD_FRAMER_CSUM_EN
  logic [7:0] csum_exp;
  assign csum_exp = {5'b0, type_q} ^ msb_q ^ lsb_q;
`endif

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    msb_d   = msb_q;
    lsb_d   = lsb_q;
    idle_d  = '0;
    err     = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (accept && (byte_i == SYNC_BYTE)) state_d = StHdr;
      end
      StHdr: begin
        if (accept) begin
          if ((byte_i[7:3] != 5'b0) || (byte_i[2:0] > MaxType)) begin
            err     = 1'b1;
            state_d = StHunt;
          end else begin
            type_d  = byte_i[2:0];
            state_d = StDmsb;
          end
        end
      end
      StDmsb: begin
        if (accept) begin
          msb_d   = byte_i;
          state_d = StDlsb;
        end
      end
      StDlsb: begin
        if (accept) begin
          lsb_d   = byte_i;
`ifdef TRAFFIC_CMD_FRAMER_CSUM_EN
          state_d = StCsum;
`else
          state_d = StEmit;
`endif
        end
      end
`ifdef TRAFFIC_CMD_FRAMER_CSUM_EN
      StCsum: begin
        if (accept) begin
          if (byte_i != csum_exp) begin
            err     = 1'b1;
            state_d = StHunt;
          end else begin
            state_d = StEmit;
          end
        end
      end
`endif
      StEmit: state_d = StHunt;
      default: state_d = StHunt;
    endcase

    // An accepted byte always beats an expiring idle count.
    if (in_frame && !accept) begin
      if (idle_q == IdleLast) begin
        err     = 1'b1;
        state_d = StHunt;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    cmd_type_d = cmd_type_q;
    cmd_data_d = cmd_data_q;
    if (err && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
    // Payload only moves on a validated frame, so failed frames never disturb it.
    if (state_d == StEmit) begin
      cmd_type_d = type_d;
      cmd_data_d = {msb_d, lsb_d};
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= StHunt;
      idle_q      <= '0;
      type_q      <= '0;
      msb_q       <= '0;
      lsb_q       <= '0;
      ready_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      cmd_type_q  <= '0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      type_q      <= type_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      ready_q     <= (state_d != StEmit);
      cmd_valid_q <= (state_d == StEmit);
      frame_err_q <= err;
      err_cnt_q   <= err_cnt_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign frame_err_o  = frame_err_q;
  assign err_cnt_o    = err_cnt_q;
  assign cmd_type_o   = cmd_type_q;
  assign cmd_data_o   = cmd_data_q;

endmodule
